stroke_line_gen: RTL and testbench

STROKE_LINE_GEN -- requirements
Module: stroke_line_gen

---
 rtl/stroke_line_gen.sv | 147 ++++++++++++++
 tb/tb_stroke_line_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/stroke_line_gen.sv
// Stroke rasteriser: turns accepted cursor points into Bresenham pixel writes,
// joining each pen-down point to the previous one.
module stroke_line_gen #(
  parameter int unsigned COORD_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ptValid,
  output logic               ptReady,
  input  logic [COORD_W-1:0] ptX,
  input  logic [COORD_W-1:0] ptY,
  input  logic               ptBrush,
  input  logic [2:0]         ptColor,
  output logic               wEn,
  output logic [COORD_W-1:0] wx,
  output logic [COORD_W-1:0] wy,
  output logic [2:0]         wColor,
  output logic               busy
);

  localparam int unsigned SW = COORD_W + 2;
  localparam int unsigned EW = COORD_W + 3;

  typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

  state_t                state;
  logic [COORD_W-1:0]    x0, y0, x1, y1;
  logic [2:0]            color_q;
  logic [COORD_W-1:0]    prevX, prevY;
  logic                  hasPrev;
  logic signed [SW-1:0]  dx, dy, err;
  logic                  sx_neg, sy_neg;

  logic signed [SW-1:0]  diff_x, diff_y, abs_x, abs_y;
  logic signed [EW-1:0]  e2, dx_e, dy_e;
  logic                  step_x, step_y, at_end;
  logic signed [SW-1:0]  add_x, add_y, err_next;
  logic [COORD_W-1:0]    x_next, y_next;

  // Line setup terms from the latched endpoints
  always_comb begin
    diff_x = $signed({2'b00, x1}) - $signed({2'b00, x0});
    diff_y = $signed({2'b00, y1}) - $signed({2'b00, y0});
    abs_x  = diff_x[SW-1] ? -diff_x : diff_x;
    abs_y  = diff_y[SW-1] ? -diff_y : diff_y;
  end

  // One Bresenham step from the pixel currently on the write port
  always_comb begin
    e2     = $signed({err, 1'b0});
    dx_e   = $signed({dx[SW-1], dx});
    dy_e   = $signed({dy[SW-1], dy});
    step_x = (e2 >= dy_e);
    step_y = (e2 <= dx_e);
    add_x  = '0;
    add_y  = '0;
    x_next = wx;
    y_next = wy;
    if (step_x) begin
      add_x  = dy;
      x_next = sx_neg ? wx - COORD_W'(1) : wx + COORD_W'(1);
    end
    if (step_y) begin
      add_y  = dx;
      y_next = sy_neg ? wy - COORD_W'(1) : wy + COORD_W'(1);
    end
    err_next = err + add_x + add_y;
    at_end   = (wx == x1) && (wy == y1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptReady <= 1'b1;
      busy    <= 1'b0;
      wEn     <= 1'b0;
      wx      <= '0;
      wy      <= '0;
      wColor  <= '0;
      prevX   <= '0;
      prevY   <= '0;
      hasPrev <= 1'b0;
      x0      <= '0;
      y0      <= '0;
      x1      <= '0;
      y1      <= '0;
      color_q <= '0;
      dx      <= '0;
      dy      <= '0;
      err     <= '0;
      sx_neg  <= 1'b0;
      sy_neg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wEn <= 1'b0;
          if (ptValid && ptReady) begin
            if (ptBrush) begin
              x1      <= ptX;
              y1      <= ptY;
              color_q <= ptColor;
              x0      <= hasPrev ? prevX : ptX;
              y0      <= hasPrev ? prevY : ptY;
              state   <= SETUP;
              ptReady <= 1'b0;
              busy    <= 1'b1;
            end else begin
              // Pen up only moves the anchor; the next pen-down starts fresh
              prevX   <= ptX;
              prevY   <= ptY;
              hasPrev <= 1'b0;
            end
          end
        end
        SETUP: begin
          dx     <= abs_x;
          dy     <= -abs_y;
          err    <= abs_x - abs_y;
          sx_neg <= diff_x[SW-1];
          sy_neg <= diff_y[SW-1];
          wx     <= x0;
          wy     <= y0;
          wColor <= color_q;
          wEn    <= 1'b1;
          state  <= DRAW;
        end
        DRAW: begin
          if (at_end) begin
            wEn     <= 1'b0;
            busy    <= 1'b0;
            ptReady <= 1'b1;
            prevX   <= x1;
            prevY   <= y1;
            hasPrev <= 1'b1;
            state   <= IDLE;
          end else begin
            wx  <= x_next;
            wy  <= y_next;
            err <= err_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stroke_line_gen.sv
// Scoreboard bench for stroke_line_gen: expected pixels are queued at accept
// time from an integer line model and consumed as wEn pulses arrive.
module tb_stroke_line_gen;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ptValid;
  logic          ptReady;
  logic [CW-1:0] ptX, ptY;
  logic          ptBrush;
  logic [2:0]    ptColor;
  logic          wEn;
  logic [CW-1:0] wx, wy;
  logic [2:0]    wColor;
  logic          busy;

  stroke_line_gen #(.COORD_W(CW)) dut (
    .clk(clk), .reset(reset),
    .ptValid(ptValid), .ptReady(ptReady),
    .ptX(ptX), .ptY(ptY), .ptBrush(ptBrush), .ptColor(ptColor),
    .wEn(wEn), .wx(wx), .wy(wy), .wColor(wColor), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  pix_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_px = 0, m_py = 0;
  bit   m_has = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference line walk; returns the number of pixels queued
  function automatic int push_line(input int x0, input int y0, input int x1, input int y1, input int c);
    int   dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
    int   dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
    int   sx  = (x0 <= x1) ? 1 : -1;
    int   sy  = (y0 <= y1) ? 1 : -1;
    int   err = dx + dy;
    int   x   = x0;
    int   y   = y0;
    int   n   = 0;
    int   e2;
    pix_t p;
    for (int i = 0; i < 1024; i++) begin
      p.x = x; p.y = y; p.c = c;
      exp_q.push_back(p);
      n++;
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    return n;
  endfunction

  // Pixel monitor
  always @(negedge clk) begin
    if (wEn === 1'b1) begin
      check("wen_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        pix_t p;
        p = exp_q.pop_front();
        check("wx", 32'(wx), 32'(p.x));
        check("wy", 32'(wy), 32'(p.y));
        check("wcolor", 32'(wColor), 32'(p.c));
      end
    end
  end

  task automatic send_point(input int x, input int y, input bit b, input int c, output int npix);
    int n;
    @(negedge clk);
    ptValid = 1'b1;
    ptX = CW'(x); ptY = CW'(y); ptBrush = b; ptColor = 3'(c);
    n = 0;
    while (ptReady !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(ptReady), 32'd1);
    npix = 0;
    if (b) begin
      npix  = push_line(m_has ? m_px : x, m_has ? m_py : y, x, y, c);
      m_has = 1'b1;
    end else begin
      m_has = 1'b0;
    end
    m_px = x;
    m_py = y;
    @(posedge clk);
    #1 ptValid = 1'b0;
  endtask

  task automatic wait_done(input int exp_cycles);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ptReady !== 1'b1 && n < 2000);
    check("stroke_cycles", 32'(n), 32'(exp_cycles));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  int np, dummy;

  initial begin
    reset = 1'b1; ptValid = 1'b0; ptX = '0; ptY = '0; ptBrush = 1'b0; ptColor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ptReady), 32'd1);
    check("rst_wen", 32'(wEn), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wx", 32'(wx), 32'd0);
    check("rst_wy", 32'(wy), 32'd0);
    check("rst_wcolor", 32'(wColor), 32'd0);
    reset = 1'b0;

    // Single pixel after reset, with cycle-exact latency
    send_point(10, 20, 1'b1, 3, np);
    @(negedge clk);
    check("setup_busy", 32'(busy), 32'd1);
    check("setup_ready", 32'(ptReady), 32'd0);
    check("setup_wen", 32'(wEn), 32'd0);
    @(negedge clk);
    check("first_wen", 32'(wEn), 32'd1);
    @(negedge clk);
    check("end_wen", 32'(wEn), 32'd0);
    check("end_ready", 32'(ptReady), 32'd1);
    check("hold_wx", 32'(wx), 32'd10);
    check("hold_wy", 32'(wy), 32'd20);
    check("hold_wcolor", 32'(wColor), 32'd3);
    check("single_drained", 32'(exp_q.size()), 32'd0);

    // Horizontal line, then a back-to-back diagonal offered while busy
    send_point(13, 20, 1'b1, 3, np);
    check("h_npix", 32'(np), 32'd4);
    send_point(10, 17, 1'b1, 6, np);
    check("diag_npix", 32'(np), 32'd4);
    wait_done(np + 2);

    // Pen up then pen down gives a lone pixel
    send_point(40, 40, 1'b0, 2, np);
    wait_done(1);
    send_point(41, 41, 1'b1, 2, np);
    wait_done(np + 2);
    check("penup_single", 32'(np), 32'd1);

    // Steep line (5,5)->(7,10)
    send_point(0, 0, 1'b0, 1, np);
    wait_done(1);
    send_point(5, 5, 1'b1, 1, np);
    wait_done(np + 2);
    send_point(7, 10, 1'b1, 4, np);
    wait_done(np + 2);
    check("steep_npix", 32'(np), 32'd6);

    // Identical endpoints
    send_point(7, 10, 1'b1, 5, np);
    wait_done(np + 2);
    check("same_npix", 32'(np), 32'd1);

    // Extremes of the coordinate range
    send_point(255, 0, 1'b1, 7, np);
    wait_done(np + 2);
    check("edge1_npix", 32'(np), 32'd249);
    send_point(0, 255, 1'b1, 1, np);
    wait_done(np + 2);
    check("edge2_npix", 32'(np), 32'd256);

    // Reset in the third DRAW cycle of (0,0)->(9,0)
    send_point(0, 0, 1'b0, 0, np);
    wait_done(1);
    send_point(0, 0, 1'b1, 5, np);
    wait_done(np + 2);
    send_point(9, 0, 1'b1, 5, np);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    ptValid = 1'b1; ptX = CW'(50); ptY = CW'(50); ptBrush = 1'b1; ptColor = 3'd6;
    @(negedge clk);
    check("midrst_wen", 32'(wEn), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(ptReady), 32'd1);
    check("midrst_left", 32'(exp_q.size()), 32'd7);
    exp_q.delete();
    reset = 1'b0;
    m_has = 1'b0;
    dummy = push_line(50, 50, 50, 50, 6);
    m_px = 50; m_py = 50; m_has = 1'b1;
    @(posedge clk);
    #1 ptValid = 1'b0;
    wait_done(3);
    repeat (20) @(negedge clk);
    check("no_resume", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
